sum_accumulator: RTL

Sequential accumulator that sums a framed stream of N-bit words using the combinational `CSaveA` adder. It feeds the adder (running total on `in1`, incoming word on `in2`) and consumes its `sum`/`cout`/`of` back into the accumulator register. It sits between an upstream valid/ready word source and a downstream valid/ready result consumer. It produces one result per frame, with sticky carry and overflow flags.

---
 rtl/sum_accumulator_pkg.sv | 13 +
 rtl/sum_accumulator_csavea.sv | 16 +
 rtl/sum_accumulator.sv | 96 +++++++++
 3 files changed

// File: rtl/sum_accumulator_pkg.sv
// Shared types and defaults for the framed word accumulator.
package sum_accumulator_pkg;

  localparam int N_DEF     = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accumulator_csavea.sv
// Combinational N-bit adder with unsigned carry-out and signed overflow flags.
module CSaveA #(
  parameter int N = 32
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         of
);

  assign {cout, sum} = {1'b0, in1} + {1'b0, in2};
  // Signed overflow: operands share a sign that the result does not.
  assign of = (in1[N-1] == in2[N-1]) && (sum[N-1] != in1[N-1]);

endmodule

// File: rtl/sum_accumulator.sv
// Sums a framed stream of words; one result per frame with sticky carry/overflow.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_of,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             cout_q, cout_d;
  logic             of_q, of_d;

  logic [N-1:0]     add_sum;
  logic             add_cout, add_of;

  CSaveA #(.N(N)) u_add (
    .in1  (acc_q),
    .in2  (in_data),
    .sum  (add_sum),
    .cout (add_cout),
    .of   (add_of)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cout_q  <= cout_d;
      of_q    <= of_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cout_d  = cout_q;
    of_d    = of_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = len;
          acc_d   = '0;
          cout_d  = 1'b0;
          of_d    = 1'b0;
          state_d = (len != '0) ? ST_ACC : ST_HOLD;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          acc_d  = add_sum;
          cout_d = cout_q | add_cout;
          of_d   = of_q | add_of;
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = acc_q;
  assign out_cout  = cout_q;
  assign out_of    = of_q;

endmodule
